mdu_div: RTL and testbench

- Iterative 32-bit integer divide/remainder unit implementing the RV32M DIV, DIVU, REM and REMU operations.
- Sits in the execute stage beside the single-cycle ALU. The ALU handles forward arithmetic in one cycle; this block performs the inverse, multi-cycle operation and stalls the core through busy/done.
- Uses radix-2 restoring division: one quotient bit per clock, with RISC-V corner cases resolved without iterating.

---
 rtl/mdu_div.sv | 98 +++++++++
 tb/tb_mdu_div.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mdu_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per clock; divide-by-zero and signed overflow finish without iterating.
module mdu_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       div_ctrl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] r_q, q_q, dvsr_q;
    logic [CW-1:0]    cnt_q;
    logic             q_neg, r_neg, sel_rem;

    logic             accept, is_signed, b_zero, ovf, special, last;
    logic [WIDTH-1:0] a_mag, b_mag, sp_res;
    logic [WIDTH:0]   sh_r, trial;
    logic [WIDTH-1:0] r_step, q_step, quot, rem;

    assign accept    = start && (state != CALC);
    assign is_signed = ~div_ctrl[0];
    assign b_zero    = (b == '0);
    assign ovf       = is_signed && (a == MIN_NEG) && (b == '1);
    assign special   = b_zero || ovf;
    assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
    assign sp_res    = b_zero ? (div_ctrl[1] ? a : '1) : (div_ctrl[1] ? '0 : MIN_NEG);
    assign last      = (cnt_q == CW'(WIDTH - 1));

    // Partial remainder is always below the divisor, so only the shifted value needs the extra bit
    assign sh_r   = {r_q, q_q[WIDTH-1]};
    assign trial  = sh_r - {1'b0, dvsr_q};
    assign r_step = trial[WIDTH] ? sh_r[WIDTH-1:0] : trial[WIDTH-1:0];
    assign q_step = {q_q[WIDTH-2:0], ~trial[WIDTH]};
    assign quot   = q_neg ? -q_step : q_step;
    assign rem    = r_neg ? -r_step : r_step;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: state_nxt = accept ? (special ? DONE : CALC) : IDLE;
            CALC:       state_nxt = last ? DONE : CALC;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // result is written only on the edge entering DONE, so it holds through a following CALC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q     <= '0;
            q_q     <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            sel_rem <= 1'b0;
            result  <= '0;
        end else if (accept) begin
            if (special) begin
                result <= sp_res;
            end else begin
                r_q     <= '0;
                q_q     <= a_mag;
                dvsr_q  <= b_mag;
                cnt_q   <= '0;
                q_neg   <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                r_neg   <= is_signed && a[WIDTH-1];
                sel_rem <= div_ctrl[1];
            end
        end else if (state == CALC) begin
            r_q   <= r_step;
            q_q   <= q_step;
            cnt_q <= cnt_q + CW'(1);
            if (last) result <= sel_rem ? rem : quot;
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);
    assign zero = (result == '0);
endmodule

// File: tb/tb_mdu_div.sv
// Directed-vector bench for mdu_div: latency, results, corner cases, reset abort, start handling.
module tb_mdu_div;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a, b;
    logic [1:0]  div_ctrl;
    logic        busy, done, zero;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    int both_err = 0;

    mdu_div #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .div_ctrl(div_ctrl),
        .busy(busy), .done(done), .result(result), .zero(zero)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (busy && done) both_err++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] ctrl, input logic [31:0] ta,
                         input logic [31:0] tb_, input int exp_lat, input logic [31:0] exp_res);
        int n;
        bit saw_busy;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_; div_ctrl = ctrl;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; div_ctrl = 2'($urandom);
        n = 1; saw_busy = 1'b0;
        while (!done && n < 100) begin
            saw_busy |= busy;
            @(negedge clk);
            n++;
        end
        chk({tag, " lat"}, 32'(n), 32'(exp_lat));
        chk({tag, " res"}, result, exp_res);
        chk({tag, " zero"}, {31'b0, zero}, {31'b0, exp_res == 32'd0});
        chk({tag, " busy"}, {31'b0, saw_busy}, {31'b0, exp_lat > 1});
    endtask

    initial begin
        int n, hold_err, late_done;
        reset = 1'b0; start = 1'b0; a = '0; b = '0; div_ctrl = '0;
        repeat (2) @(negedge clk);
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst done", {31'b0, done}, 32'd0);
        chk("rst result", result, 32'd0);
        chk("rst zero", {31'b0, zero}, 32'd1);
        reset = 1'b1;

        do_op("divu",   2'b01, 32'd100, 32'd7, 33, 32'd14);
        do_op("remu",   2'b11, 32'd100, 32'd7, 33, 32'd2);
        do_op("div neg", 2'b00, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
        do_op("rem neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
        do_op("div negb", 2'b00, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD);
        do_op("div0 div",  2'b00, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
        do_op("div0 divu", 2'b01, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
        do_op("div0 rem",  2'b10, 32'd5, 32'd0, 1, 32'd5);
        do_op("div0 remu", 2'b11, 32'd5, 32'd0, 1, 32'd5);
        do_op("ovf div",  2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        do_op("ovf rem",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);
        do_op("ovf divu", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0);
        do_op("ovf remu", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000);

        // start during CALC must be ignored
        @(negedge clk);
        start = 1'b1; a = 32'd100; b = 32'd7; div_ctrl = 2'b01;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 100) begin
            if (n == 5) begin
                start = 1'b1; a = 32'd50; b = 32'd5; div_ctrl = 2'b11;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        chk("ign lat", 32'(n), 32'd33);
        chk("ign res", result, 32'd14);

        // back-to-back start in the DONE cycle
        start = 1'b1; a = 32'd1000; b = 32'd7; div_ctrl = 2'b11;
        @(negedge clk);
        start = 1'b0;
        n = 1; hold_err = 0;
        while (!done && n < 100) begin
            if (result !== 32'd14) hold_err++;
            @(negedge clk);
            n++;
        end
        chk("b2b lat", 32'(n), 32'd33);
        chk("b2b res", result, 32'd6);
        chk("b2b hold", 32'(hold_err), 32'd0);

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        start = 1'b1; a = 32'd1000; b = 32'd10; div_ctrl = 2'b01;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort busy", {31'b0, busy}, 32'd0);
        chk("abort done", {31'b0, done}, 32'd0);
        chk("abort result", result, 32'd0);
        chk("abort zero", {31'b0, zero}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        late_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) late_done++;
        end
        chk("abort no done", 32'(late_done), 32'd0);
        do_op("post rst", 2'b01, 32'd1000, 32'd10, 33, 32'd100);

        chk("busy&done", 32'(both_err), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
